// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one step per cycle, with a single-cycle fast path for divide-by-zero and signed overflow.
module ex_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic            hold_flag_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          func3_q, func3_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     opd_q, opd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                a_neg_q, a_neg_d;
  logic [4:0]          rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic                rd_wen_q, rd_wen_d;
  logic                busy_q, busy_d;

  // Decode of the incoming instruction
  logic                is_div_i, a_sgn_i, b_sgn_i, a_neg_i, b_neg_i;
  logic                div_zero_i, div_ovf_i;
  logic [XLEN-1:0]     mag_a_i, mag_b_i, fast_res_i;

  assign is_div_i   = func3_i[2];
  assign a_sgn_i    = is_div_i ? ~func3_i[0] : (func3_i[1:0] != 2'b11);
  assign b_sgn_i    = is_div_i ? ~func3_i[0] : ~func3_i[1];
  assign a_neg_i    = a_sgn_i & op1_i[XLEN-1];
  assign b_neg_i    = b_sgn_i & op2_i[XLEN-1];
  assign mag_a_i    = a_neg_i ? -op1_i : op1_i;
  assign mag_b_i    = b_neg_i ? -op2_i : op2_i;
  assign div_zero_i = is_div_i & (op2_i == '0);
  assign div_ovf_i  = is_div_i & ~func3_i[0] & (op1_i == MOST_NEG) & (&op2_i);
  assign fast_res_i = div_zero_i ? (func3_i[1] ? op1_i : '1)
                                 : (func3_i[1] ? '0 : op1_i);

  // One iteration. Multiply keeps {partial_product, multiplier} in acc; divide keeps
  // {remainder, dividend/quotient}. opd_q holds the multiplicand or the divisor.
  logic [XLEN:0]       mul_sum, div_trial;
  logic [2*XLEN-1:0]   acc_step, prod;
  logic [XLEN-1:0]     quo, rem, result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    // A borrow means the shifted remainder is below the divisor: keep it, quotient bit 0.
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
    if (func3_q[2]) begin
      acc_step = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod = neg_q   ? -acc_step                    : acc_step;
    quo  = neg_q   ? -acc_step[XLEN-1:0]          : acc_step[XLEN-1:0];
    rem  = a_neg_q ? -acc_step[2*XLEN-1:XLEN]     : acc_step[2*XLEN-1:XLEN];
    unique case (func3_q)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase
  end

  // NOTE: every *_d starts from its hold value so no path through the case leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func3_d   = func3_q;
    rd_d      = rd_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    a_neg_d   = a_neg_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_wen_d  = rd_wen_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          func3_d = func3_i;
          rd_d    = rd_addr_i;
          neg_d   = a_neg_i ^ b_neg_i;
          a_neg_d = a_neg_i;
          cnt_d   = CNT_W'(XLEN);
          acc_d   = {{XLEN{1'b0}}, (is_div_i ? mag_a_i : mag_b_i)};
          opd_d   = is_div_i ? mag_b_i : mag_a_i;
          if (div_zero_i || div_ovf_i) begin
            state_d   = S_DONE;
            rd_data_d = fast_res_i;
            rd_addr_d = rd_addr_i;
            rd_wen_d  = (rd_addr_i != 5'd0);
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = S_DONE;
            rd_data_d = result;
            rd_addr_d = rd_q;
            rd_wen_d  = (rd_q != 5'd0);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        rd_addr_d = 5'd0;
        rd_wen_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      func3_q   <= '0;
      rd_q      <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      a_neg_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wen_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func3_q   <= func3_d;
      rd_q      <= rd_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      a_neg_q   <= a_neg_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_wen_q  <= rd_wen_d;
      busy_q    <= busy_d;
    end
  end

  // A redirect landing on the result cycle must suppress the write.
  assign rd_wen_o    = rd_wen_q & ~flush_i;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign busy_o      = busy_q;
  assign hold_flag_o = ((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_BUSY);

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: expected writes are queued at issue and matched
// (address, data, cycle) by a monitor whenever rd_wen_o fires.
module tb_ex_mdu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic [2:0]      func3_i = '0;
  logic [XLEN-1:0] op1_i = '0;
  logic [XLEN-1:0] op2_i = '0;
  logic [4:0]      rd_addr_i = '0;
  logic            flush_i = 1'b0;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            rd_wen_o;
  logic            hold_flag_o;
  logic            busy_o;

  ex_mdu #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .func3_i     (func3_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wen_o    (rd_wen_o),
    .hold_flag_o (hold_flag_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask

  // Reference arithmetic in 64-bit two's complement.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic        [63:0] ua, ub, p;
    logic signed [31:0] s1, s2;
    logic        [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    s1 = a;
    s2 = b;
    r  = '0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(s1 / s2);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(s1 % s2);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Write monitor: every strobe must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (rd_wen_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wen", {59'b0, rd_addr_o}, 64'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", {59'b0, rd_addr_o}, {59'b0, mon_e.addr});
        check("wr_data", {32'b0, rd_data_o}, {32'b0, mon_e.data});
        check("wr_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start_i   = 1'b1;
    func3_i   = f3;
    op1_i     = a;
    op2_i     = b;
    rd_addr_i = rd;
  endtask

  task automatic scramble_inputs();
    start_i   = 1'b0;
    func3_i   = 3'($urandom);
    op1_i     = $urandom;
    op2_i     = $urandom;
    rd_addr_i = 5'($urandom);
  endtask

  // Called just after a rising edge (cycle T); returns just after the edge of T+lat+1.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] want,
                        input bit poke);
    int  t0, lat;
    bit  fast;
    exp_t e;
    fast = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    lat  = fast ? 1 : XLEN + 1;
    t0   = cyc;
    drive_start(f3, a, b, rd);
    if (rd != 0) begin
      e.addr = rd; e.data = want; e.due = t0 + lat;
      sb_q.push_back(e);
    end
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, {63'b0, hold_flag_o}, {63'b0, (k < lat)});
      check({tag, "_busy"}, {63'b0, busy_o}, {63'b0, (k > 0)});
      @(posedge clk); #1;
      scramble_inputs();
      if (poke && (k + 1 == 3 || k + 1 == lat)) begin
        start_i   = 1'b1;
        rd_addr_i = 5'd31;
      end
    end
    check({tag, "_idle_busy"}, {63'b0, busy_o}, 64'h0);
    check({tag, "_idle_addr"}, {59'b0, rd_addr_o}, 64'h0);
  endtask

  int t0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_wen",  {63'b0, rd_wen_o}, 64'h0);
    check("rst_addr", {59'b0, rd_addr_o}, 64'h0);
    check("rst_data", {32'b0, rd_data_o}, 64'h0);
    check("rst_busy", {63'b0, busy_o}, 64'h0);
    check("rst_hold", {63'b0, hold_flag_o}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed operations, with stray starts during BUSY and DONE on the first one.
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 1'b0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 1'b0);
    run_op("divu",   3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        1'b0);
    run_op("remu",   3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         1'b0);
    run_op("divu0",  3'd5, 32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1);
    run_op("rem0",   3'd6, 32'h1234,      32'd0,         5'd14, 32'h1234,      1'b0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0,         1'b0);

    // Randomised operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f3 = 3'($urandom);
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      rd = 5'($urandom_range(1, 31));
      run_op("rand", f3, a, b, rd, model(f3, a, b), 1'b0);
    end

    // start together with flush in IDLE is ignored.
    drive_start(3'd0, 32'd3, 32'd4, 5'd2);
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_idle_hold", {63'b0, hold_flag_o}, 64'h0);
    @(posedge clk); #1;
    scramble_inputs();
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", {63'b0, busy_o}, 64'h0);
    @(posedge clk); #1;

    // Flush in BUSY at T+10, then a fresh DIVU accepted at T+11.
    t0 = cyc;
    drive_start(3'd0, 32'd9, 32'd9, 5'd20);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      scramble_inputs();
      if (k == 10) flush_i = 1'b1;
      @(negedge clk);
      check("flush_busy_hold", {63'b0, hold_flag_o}, 64'h1);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    check("flush_busy_rel_hold", {63'b0, hold_flag_o}, 64'h0);
    check("flush_busy_rel_busy", {63'b0, busy_o}, 64'h0);
    check("flush_busy_restart_cycle", 64'(cyc), 64'(t0 + 11));
    run_op("after_flush", 3'd5, 32'd1000, 32'd10, 5'd21, 32'd100, 1'b0);

    // Flush landing on the DONE cycle suppresses the write.
    drive_start(3'd5, 32'd50, 32'd5, 5'd22);
    for (int k = 1; k <= XLEN + 1; k++) begin
      @(posedge clk); #1;
      scramble_inputs();
      if (k == XLEN + 1) flush_i = 1'b1;
      @(negedge clk);
      if (k == XLEN + 1) begin
        check("flush_done_wen",  {63'b0, rd_wen_o}, 64'h0);
        check("flush_done_hold", {63'b0, hold_flag_o}, 64'h0);
      end
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_done_busy", {63'b0, busy_o}, 64'h0);
    @(posedge clk); #1;

    // Known non-zero result, then synchronous reset at T+5 of a DIV.
    run_op("pre_rst", 3'd5, 32'd1000, 32'd3, 5'd4, 32'd333, 1'b0);
    drive_start(3'd4, 32'd1000, 32'd7, 5'd3);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      scramble_inputs();
      if (k == 5) rst = 1'b1;
      @(negedge clk);
      if (k == 5) begin
        check("rst_pre_data", {32'b0, rd_data_o}, 64'd333);
        check("rst_pre_hold", {63'b0, hold_flag_o}, 64'h1);
      end
      if (k == 6) begin
        check("rst_mid_wen",  {63'b0, rd_wen_o}, 64'h0);
        check("rst_mid_addr", {59'b0, rd_addr_o}, 64'h0);
        check("rst_mid_data", {32'b0, rd_data_o}, 64'h0);
        check("rst_mid_busy", {63'b0, busy_o}, 64'h0);
        check("rst_mid_hold", {63'b0, hold_flag_o}, 64'h0);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // rd = 0: full hold timing, no write.
    run_op("mul_rd0", 3'd0, 32'd12, 32'd12, 5'd0, 32'd144, 1'b0);
    run_op("last",    3'd0, 32'd12, 32'd12, 5'd1, 32'd144, 1'b0);

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
